// File: rtl/syscall_console_queue_pkg.sv
// Package: syscall_pkg
// Purpose: shared constants and state encoding for the syscall console queue.
//   SYSCALL_PRINT_INT / SYSCALL_EXIT are the full 32-bit $v0 codes handled by
//   the back-end; every other code is reported as unknown.
package syscall_pkg;

  localparam logic [31:0] SYSCALL_PRINT_INT = 32'd1;
  localparam logic [31:0] SYSCALL_EXIT      = 32'd10;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } queueState_t;

endpackage

// File: rtl/sync_fifo.sv
// Module: sync_fifo
// Purpose: single-clock FIFO with registered pointers and an occupancy count.
//   The head entry is presented combinationally and reads as zero when empty.
// Ports:
//   clk, reset       system clock, synchronous active-high reset
//   push, pushData   write request and data (ignored when full)
//   pop              read request (ignored when empty)
//   full, empty      occupancy flags
//   count            entries held, 0..DEPTH
//   head             oldest entry, 0 when empty
module sync_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [DATA_W-1:0]        pushData,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [DATA_W-1:0]        head
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rdPtr;
  logic [PTR_W-1:0]  wrPtr;
  logic              doPush;
  logic              doPop;

  assign full   = (count == (PTR_W+1)'(DEPTH));
  assign empty  = (count == '0);
  assign doPush = push & ~full;
  assign doPop  = pop & ~empty;
  assign head   = empty ? '0 : mem[rdPtr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      unique case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately left out of reset; the count gates every
  // read, so stale contents are never visible and the array can map to RAM.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

endmodule

// File: rtl/syscall_console_queue.sv
// Module: syscall_console_queue
// Purpose: buffered syscall back-end. Print-integer requests (v0==1) queue a0
//   for the console; exit (v0==10) stalls the core, drains the queue and then
//   raises a sticky halt. Unsupported codes give a one-cycle err_unknown pulse.
// Ports:
//   clk, reset             system clock, synchronous active-high reset
//   syscall_en, v0, a0     syscall request from the execute stage
//   stall                  hold the current instruction (combinational)
//   out_valid, out_data    FIFO head towards the console
//   out_ready              console accepts out_data this cycle
//   halt                   program finished and queue empty (sticky)
//   err_unknown            one-cycle pulse for an unsupported v0 code
module syscall_console_queue
  import syscall_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              syscall_en,
  input  logic [31:0]       v0,
  input  logic [DATA_W-1:0] a0,
  output logic              stall,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              halt,
  output logic              err_unknown
);

  queueState_t               state;
  queueState_t               nextState;
  logic                      pushReq;
  logic                      popReq;
  logic                      errNext;
  logic                      fifoFull;
  logic                      fifoEmpty;
  logic [$clog2(DEPTH):0]    fifoCount;

  sync_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (pushReq),
    .pushData (a0),
    .pop      (popReq),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .count    (fifoCount),
    .head     (out_data)
  );

  assign out_valid = ~fifoEmpty;
  // The console may drain in any state, including while halted.
  assign popReq    = out_valid & out_ready;

  // NOTE: every output of this block gets a default first so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    nextState = state;
    stall     = (state != RUN);
    pushReq   = 1'b0;
    errNext   = 1'b0;
    unique case (state)
      RUN: begin
        if (syscall_en) begin
          if (v0 == SYSCALL_PRINT_INT) begin
            // Full is judged before this edge's pop, so a simultaneous pop
            // frees space only for the re-presented request next cycle.
            if (fifoFull) stall   = 1'b1;
            else          pushReq = 1'b1;
          end else if (v0 == SYSCALL_EXIT) begin
            nextState = DRAIN;
          end else begin
            errNext = 1'b1;
          end
        end
      end
      DRAIN:   if (fifoCount == '0) nextState = HALTED;
      HALTED:  nextState = HALTED;
      default: nextState = RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      halt        <= 1'b0;
      err_unknown <= 1'b0;
    end else begin
      state       <= nextState;
      halt        <= (nextState == HALTED);
      err_unknown <= errNext;
    end
  end

endmodule
